pwm_multichannel: RTL and testbench

Parametrised successor of the fixed 16-channel, 8-bit PWM peripheral. Provides NUM_CH independent PWM outputs sharing one prescaled timebase, with edge- or center-aligned mode. Duty updates are double-buffered so they apply glitch-free at period boundaries. It sits behind the SPI register block: the SPI side supplies the enable vectors and per-channel duty writes, and the outputs drive the uo_out/uio_out pins.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_timebase.sv | 77 +++++++
 rtl/pwm_multichannel.sv | 76 +++++++
 tb/tb_pwm_multichannel.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types, limits and helpers for the multichannel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int MAX_CH    = 32;
    localparam int MIN_CNT_W = 4;
    localparam int MAX_CNT_W = 16;

    // Channel-index width; a single channel still gets a 1-bit index port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and edge/center-aligned period counter for all PWM channels.
// Flags the period boundary so channels can swap in their buffered duties.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary,
    output logic               period_start
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_cnt_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               tick;
    pwm_dir_e           dir;
    pwm_dir_e           dir_nxt;
    pwm_mode_e          mode_act;
    pwm_mode_e          mode_act_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_act     <= PWM_EDGE;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= presc_cnt_nxt;
            cnt          <= cnt_nxt;
            dir          <= dir_nxt;
            mode_act     <= mode_act_nxt;
            period_start <= boundary;
        end
    end

    // A prescale lowered below the running count wraps without producing a tick.
    always_comb begin
        tick          = (presc_cnt == prescale);
        presc_cnt_nxt = (presc_cnt >= prescale) ? '0 : presc_cnt + PRESC_ONE;
        cnt_nxt       = cnt;
        dir_nxt       = dir;
        mode_act_nxt  = mode_act;
        boundary      = 1'b0;
        if (tick) begin
            if (mode_act == PWM_EDGE) begin
                cnt_nxt  = cnt + CNT_ONE;
                boundary = (cnt == CNT_MAX);
            end else if (dir == DIR_UP) begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt = cnt - CNT_ONE;
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else begin
                cnt_nxt  = cnt - CNT_ONE;
                boundary = (cnt == CNT_ONE);
            end
        end
        if (boundary) begin
            mode_act_nxt = pwm_mode_e'(mode);
            dir_nxt      = DIR_UP;
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH PWM outputs on one shared timebase with double-buffered duty registers
// that swap in glitch-free at each period boundary.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter  int NUM_CH  = 16,
    parameter  int CNT_W   = 8,
    parameter  int PRESC_W = 8,
    localparam int CH_W    = clog2_min1(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  out_en,
    input  logic [NUM_CH-1:0]  pwm_en,
    input  logic               wr_valid,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [CNT_W-1:0]   wr_duty,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               mode,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               period_start
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic [NUM_CH-1:0] raw;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale),
        .mode         (mode),
        .cnt          (cnt),
        .boundary     (boundary),
        .period_start (period_start)
    );

    // Out-of-range channel indices match no IDX, so those writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        logic [CNT_W-1:0] pending;
        logic [CNT_W-1:0] active;

        always_ff @(posedge clk) begin
            if (rst) begin
                pending <= '0;
                active  <= '0;
            end else begin
                if (wr_valid && (wr_ch == IDX)) begin
                    pending <= wr_duty;
                end
                if (boundary) begin
                    active <= pending;
                end
            end
        end

        assign raw[i] = (active == CNT_MAX) ? 1'b1 : (cnt < active);
    end

    // Disabled PWM on an enabled output holds the pin statically high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= out_en & (~pwm_en | raw);
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scenario bench for pwm_multichannel: expected window statistics are queued per
// scenario, then popped and compared once the measurement window has been sampled.
module tb_pwm_multichannel;

    localparam int NUM_CH  = 16;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 8;

    localparam int K_HI   = 0;
    localparam int K_FL   = 1;
    localparam int K_LAST = 2;
    localparam int K_PS   = 3;

    typedef struct packed {
        int kind;
        int ch;
        int value;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CH-1:0]  out_en;
    logic [NUM_CH-1:0]  pwm_en;
    logic               wr_valid;
    logic [3:0]         wr_ch;
    logic [CNT_W-1:0]   wr_duty;
    logic [PRESC_W-1:0] prescale;
    logic               mode;
    logic [NUM_CH-1:0]  pwm_out;
    logic               period_start;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   hi_cnt[NUM_CH];
    int   first_low[NUM_CH];
    logic last_val[NUM_CH];
    int   ps_pos;
    int   n_samp;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .out_en       (out_en),
        .pwm_en       (pwm_en),
        .wr_valid     (wr_valid),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .prescale     (prescale),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic string kind_name(input int k);
        case (k)
            K_HI:    return "high_count";
            K_FL:    return "first_low_sample";
            K_LAST:  return "last_sample";
            default: return "period_start_pos";
        endcase
    endfunction

    function automatic int observe(input int kind, input int ch);
        case (kind)
            K_HI:    return hi_cnt[ch];
            K_FL:    return first_low[ch];
            K_LAST:  return (last_val[ch] === 1'b1) ? 1 : 0;
            default: return ps_pos;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_meas();
        n_samp = 0;
        ps_pos = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            hi_cnt[c]    = 0;
            first_low[c] = 0;
            last_val[c]  = 1'b0;
        end
    endtask

    // Sample index k reflects the counter value reached k-1 clocks after the window start.
    task automatic measure(input int n);
        for (int s = 0; s < n; s++) begin
            step();
            n_samp++;
            if (period_start === 1'b1 && ps_pos == 0) ps_pos = n_samp;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pwm_out[c] === 1'b1) hi_cnt[c]++;
                else if (first_low[c] == 0) first_low[c] = n_samp;
                last_val[c] = pwm_out[c];
            end
        end
    endtask

    task automatic wait_ps(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (period_start !== 1'b1 && k < budget);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_period_start: got no pulse in %0d clk, expected one", budget);
        end
    endtask

    task automatic write_duty(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_ch    = 4'(ch);
        wr_duty  = CNT_W'(duty);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        out_en   = '1;
        pwm_en   = '0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        prescale = '0;
        mode     = 1'b0;
        step();
        step();
        checks++;
        if (pwm_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset pwm_out: got %h, expected 0000", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset period_start: got %b, expected 0", period_start);
        end
        rst = 1'b0;
        step();
        checks++;
        if (pwm_out !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL static_high pwm_out: got %h, expected ffff", pwm_out);
        end
        pwm_en = '1;
        step();
        checks++;
        if (pwm_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL zero_duty pwm_out: got %h, expected 0000", pwm_out);
        end
    endtask

    task automatic test_edge();
        exp_t e;
        int   got;
        wait_ps(600);
        write_duty(0, 128);
        wait_ps(600);
        exp_q.push_back('{K_HI, 0, 128});
        exp_q.push_back('{K_FL, 0, 129});
        exp_q.push_back('{K_PS, 0, 256});
        exp_q.push_back('{K_HI, 1, 0});
        clear_meas();
        measure(256);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = observe(e.kind, e.ch);
            checks++;
            if (got !== e.value) begin
                errors++;
                $display("[TB] FAIL edge %s ch%0d: got %0d, expected %0d", kind_name(e.kind), e.ch, got, e.value);
            end
        end
    endtask

    task automatic test_extremes();
        exp_t e;
        int   got;
        write_duty(1, 0);
        write_duty(2, 255);
        write_duty(3, 128);
        write_duty(4, 0);
        out_en = 16'hFFFF & ~16'h0008;
        pwm_en = 16'hFFFF & ~16'h0010;
        wait_ps(600);
        exp_q.push_back('{K_HI, 0, 128});
        exp_q.push_back('{K_HI, 1, 0});
        exp_q.push_back('{K_HI, 2, 256});
        exp_q.push_back('{K_HI, 3, 0});
        exp_q.push_back('{K_HI, 4, 256});
        exp_q.push_back('{K_PS, 0, 256});
        clear_meas();
        measure(256);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = observe(e.kind, e.ch);
            checks++;
            if (got !== e.value) begin
                errors++;
                $display("[TB] FAIL extremes %s ch%0d: got %0d, expected %0d", kind_name(e.kind), e.ch, got, e.value);
            end
        end
        out_en = '1;
        pwm_en = '1;
    endtask

    // Each window begins on a period_start sample; the second pair of windows
    // places the write exactly on the boundary edge.
    task automatic test_shadow();
        exp_t e;
        int   got;
        for (int w = 0; w < 5; w++) begin
            case (w)
                0: begin
                    exp_q.push_back('{K_HI, 0, 128});
                    exp_q.push_back('{K_PS, 0, 256});
                end
                1: begin
                    exp_q.push_back('{K_HI, 0, 32});
                    exp_q.push_back('{K_FL, 0, 33});
                    exp_q.push_back('{K_PS, 0, 256});
                end
                2, 3: begin
                    exp_q.push_back('{K_HI, 0, 32});
                    exp_q.push_back('{K_PS, 0, 256});
                end
                default: begin
                    exp_q.push_back('{K_HI, 0, 200});
                    exp_q.push_back('{K_FL, 0, 201});
                end
            endcase
            clear_meas();
            if (w == 0 || w == 2) begin
                measure((w == 0) ? 10 : 255);
                wr_valid = 1'b1;
                wr_ch    = 4'd0;
                wr_duty  = (w == 0) ? 8'd32 : 8'd200;
                measure(1);
                wr_valid = 1'b0;
                measure((w == 0) ? 245 : 0);
            end else begin
                measure(256);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = observe(e.kind, e.ch);
                checks++;
                if (got !== e.value) begin
                    errors++;
                    $display("[TB] FAIL shadow_w%0d %s ch%0d: got %0d, expected %0d", w, kind_name(e.kind), e.ch, got, e.value);
                end
            end
        end
    endtask

    task automatic test_center();
        exp_t e;
        int   got;
        mode = 1'b1;
        write_duty(0, 64);
        wait_ps(600);
        exp_q.push_back('{K_HI, 0, 127});
        exp_q.push_back('{K_FL, 0, 65});
        exp_q.push_back('{K_LAST, 0, 1});
        exp_q.push_back('{K_PS, 0, 510});
        clear_meas();
        measure(510);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = observe(e.kind, e.ch);
            checks++;
            if (got !== e.value) begin
                errors++;
                $display("[TB] FAIL center %s ch%0d: got %0d, expected %0d", kind_name(e.kind), e.ch, got, e.value);
            end
        end
        mode = 1'b0;
        write_duty(0, 128);
        wait_ps(600);
    endtask

    // Prescale drops 3 -> 1 while the prescaler sits at 2: it wraps with no tick.
    task automatic test_prescaler();
        exp_t e;
        int   got;
        prescale = 8'd3;
        wait_ps(2100);
        for (int w = 0; w < 2; w++) begin
            if (w == 0) begin
                exp_q.push_back('{K_HI, 0, 512});
                exp_q.push_back('{K_FL, 0, 513});
                exp_q.push_back('{K_PS, 0, 1024});
            end else begin
                exp_q.push_back('{K_HI, 0, 261});
                exp_q.push_back('{K_FL, 0, 262});
                exp_q.push_back('{K_PS, 0, 517});
            end
            clear_meas();
            if (w == 0) begin
                measure(1024);
            end else begin
                measure(6);
                prescale = 8'd1;
                measure(511);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = observe(e.kind, e.ch);
                checks++;
                if (got !== e.value) begin
                    errors++;
                    $display("[TB] FAIL prescale_w%0d %s ch%0d: got %0d, expected %0d", w, kind_name(e.kind), e.ch, got, e.value);
                end
            end
        end
        prescale = 8'd0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   got;
        clear_meas();
        measure(100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (pwm_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL mid_reset pwm_out: got %h, expected 0000", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset period_start: got %b, expected 0", period_start);
        end
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back('{K_HI, 0, 0});
            exp_q.push_back('{K_HI, 2, 0});
            exp_q.push_back('{K_HI, 3, 0});
            exp_q.push_back('{K_PS, 0, 256});
            clear_meas();
            measure(256);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = observe(e.kind, e.ch);
                checks++;
                if (got !== e.value) begin
                    errors++;
                    $display("[TB] FAIL mid_reset_w%0d %s ch%0d: got %0d, expected %0d", w, kind_name(e.kind), e.ch, got, e.value);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_extremes();
        test_shadow();
        test_center();
        test_prescaler();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
